// File: rtl/rpsc_rf_sequencer_if.sv
// Status inputs and command outputs of the RF turn-on sequencer.
// RPSC_SEQ_FAULT_COUNT_EN adds the saturating fault_count output.
interface rpsc_rf_sequencer_if;
    logic       g2_on_perm;
    logic       g2_on;
    logic       dr_amp_on_perm;
    logic       dr_amp_on;
    logic       rf_reduced_permitted;
    logic       rf_permitted;
    logic       ca_delay;
    logic       start_req;
    logic       stop_req;
    logic       fault_clr;
    logic       g2_on_cmd;
    logic       dr_amp_on_cmd;
    logic       rf_reduced_en;
    logic       rf_full_en;
    logic       fault;
    logic [2:0] fault_code;
    logic [2:0] state;
`ifdef RPSC_SEQ_FAULT_COUNT_EN
    logic [7:0] fault_count;

    modport master (
        output g2_on_perm, g2_on, dr_amp_on_perm, dr_amp_on, rf_reduced_permitted,
               rf_permitted, ca_delay, start_req, stop_req, fault_clr,
        input  g2_on_cmd, dr_amp_on_cmd, rf_reduced_en, rf_full_en, fault,
               fault_code, state, fault_count
    );
    modport slave (
        input  g2_on_perm, g2_on, dr_amp_on_perm, dr_amp_on, rf_reduced_permitted,
               rf_permitted, ca_delay, start_req, stop_req, fault_clr,
        output g2_on_cmd, dr_amp_on_cmd, rf_reduced_en, rf_full_en, fault,
               fault_code, state, fault_count
    );
`else
    modport master (
        output g2_on_perm, g2_on, dr_amp_on_perm, dr_amp_on, rf_reduced_permitted,
               rf_permitted, ca_delay, start_req, stop_req, fault_clr,
        input  g2_on_cmd, dr_amp_on_cmd, rf_reduced_en, rf_full_en, fault,
               fault_code, state
    );
    modport slave (
        input  g2_on_perm, g2_on, dr_amp_on_perm, dr_amp_on, rf_reduced_permitted,
               rf_permitted, ca_delay, start_req, stop_req, fault_clr,
        output g2_on_cmd, dr_amp_on_cmd, rf_reduced_en, rf_full_en, fault,
               fault_code, state
    );
`endif
endinterface

// File: rtl/rpsc_rf_sequencer.sv
// RF chain sequencer: G2 -> driver amp -> reduced RF -> full RF, with step timeouts and
// latched faults. Optional RPSC_SEQ_FAULT_COUNT_EN adds a saturating fault counter.
module rpsc_rf_sequencer #(
    parameter int STEP_TIMEOUT    = 1000,
    parameter int CA_DELAY_CYCLES = 5000,
    parameter int CNT_W           = 16
) (
    input logic                 clk,
    input logic                 reset,
    rpsc_rf_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_G2_RAMP = 3'd1, S_DRV_RAMP = 3'd2, S_RF_REDUCED = 3'd3,
        S_RF_FULL = 3'd4, S_SHUTDOWN = 3'd5, S_FAULT = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(STEP_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CA_LAST = CNT_W'(CA_DELAY_CYCLES - 1);

    state_t           st, nxt, adv_st;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       nxt_code, perm_code, to_code;
    logic             adv, timeout, run_g2, run_dr;

    assign timeout = (cnt == TO_LAST);
    assign run_g2  = (st == S_G2_RAMP) || (st == S_DRV_RAMP) || (st == S_RF_REDUCED) || (st == S_RF_FULL);
    assign run_dr  = (st == S_DRV_RAMP) || (st == S_RF_REDUCED) || (st == S_RF_FULL);

    always_comb begin
        adv       = 1'b0;
        adv_st    = st;
        to_code   = 3'd0;
        perm_code = 3'd0;
        case (st)
            S_G2_RAMP:    begin adv = bus.g2_on && bus.dr_amp_on_perm; adv_st = S_DRV_RAMP; to_code = 3'd1; end
            S_DRV_RAMP:   begin adv = bus.dr_amp_on && bus.rf_reduced_permitted; adv_st = S_RF_REDUCED; to_code = 3'd2; end
            S_RF_REDUCED: begin adv = (cnt >= CA_LAST) && bus.ca_delay && bus.rf_permitted; adv_st = S_RF_FULL; end
            // Falling back to reduced RF is a normal step; the no-permit case is caught below.
            S_RF_FULL:    begin adv = !bus.rf_permitted; adv_st = S_RF_REDUCED; end
            default:      ;
        endcase
        // Lowest code wins when several permits drop together.
        if (run_g2 && !bus.g2_on_perm)                                          perm_code = 3'd3;
        else if (run_dr && !bus.dr_amp_on_perm)                                 perm_code = 3'd4;
        else if (st == S_RF_REDUCED && !bus.rf_reduced_permitted)               perm_code = 3'd6;
        else if (st == S_RF_FULL && !bus.rf_permitted && !bus.rf_reduced_permitted) perm_code = 3'd6;
    end

    always_comb begin
        nxt      = st;
        nxt_code = 3'd0;
        case (st)
            S_IDLE:
                if (bus.start_req && bus.g2_on_perm && !bus.stop_req) nxt = S_G2_RAMP;
            S_G2_RAMP, S_DRV_RAMP, S_RF_REDUCED, S_RF_FULL: begin
                if (perm_code != 3'd0) begin
                    nxt      = S_FAULT;
                    nxt_code = perm_code;
                end else if (to_code != 3'd0 && timeout && !adv) begin
                    nxt      = S_FAULT;
                    nxt_code = to_code;
                end else if (bus.stop_req) begin
                    nxt = S_SHUTDOWN;
                end else if (adv) begin
                    nxt = adv_st;
                end
            end
            S_SHUTDOWN:
                if (!bus.g2_on) nxt = S_IDLE;
                else if (timeout) begin
                    nxt      = S_FAULT;
                    nxt_code = 3'd5;
                end
            S_FAULT:
                if (bus.fault_clr && !bus.start_req) nxt = S_IDLE;
            default:
                nxt = S_IDLE;
        endcase
    end

    assign bus.state = st;

    always_ff @(posedge clk) begin
        if (reset) begin
            st                <= S_IDLE;
            cnt               <= '0;
            bus.g2_on_cmd     <= 1'b0;
            bus.dr_amp_on_cmd <= 1'b0;
            bus.rf_reduced_en <= 1'b0;
            bus.rf_full_en    <= 1'b0;
            bus.fault         <= 1'b0;
            bus.fault_code    <= 3'd0;
        end else begin
            st  <= nxt;
            cnt <= (nxt != st) ? '0 : ((&cnt) ? cnt : cnt + 1'b1);
            // In shutdown G2 stays enabled until the driver amp reports off, then stays off.
            bus.g2_on_cmd     <= (nxt == S_G2_RAMP) || (nxt == S_DRV_RAMP) || (nxt == S_RF_REDUCED) ||
                                 (nxt == S_RF_FULL) ||
                                 ((nxt == S_SHUTDOWN) && ((st != S_SHUTDOWN) || (bus.g2_on_cmd && bus.dr_amp_on)));
            bus.dr_amp_on_cmd <= (nxt == S_DRV_RAMP) || (nxt == S_RF_REDUCED) || (nxt == S_RF_FULL);
            bus.rf_reduced_en <= (nxt == S_RF_REDUCED);
            bus.rf_full_en    <= (nxt == S_RF_FULL);
            bus.fault         <= (nxt == S_FAULT);
            bus.fault_code    <= (nxt != S_FAULT) ? 3'd0 : ((st == S_FAULT) ? bus.fault_code : nxt_code);
        end
    end

`ifdef RPSC_SEQ_FAULT_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            bus.fault_count <= 8'd0;
        else if (nxt == S_FAULT && st != S_FAULT && bus.fault_count != 8'hFF)
            bus.fault_count <= bus.fault_count + 8'd1;
    end
`endif
endmodule

// File: tb/tb_rpsc_rf_sequencer.sv
// Directed bench for rpsc_rf_sequencer; expectations are queued by the stimulus and
// compared by a negedge monitor.
module tb_rpsc_rf_sequencer;
    localparam int ST = 8;
    localparam int CA = 4;

    typedef struct {
        string      name;
        logic [2:0] st;
        logic [3:0] cmds;
        logic       flt;
        logic [2:0] code;
        logic [7:0] fcnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    int   efc   = 0;
    exp_t q[$];

    rpsc_rf_sequencer_if bus();

    rpsc_rf_sequencer #(.STEP_TIMEOUT(ST), .CA_DELAY_CYCLES(CA), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            logic [10:0] act, req;
            e   = q.pop_front();
            act = {bus.state, bus.g2_on_cmd, bus.dr_amp_on_cmd, bus.rf_reduced_en, bus.rf_full_en,
                   bus.fault, bus.fault_code};
            req = {e.st, e.cmds, e.flt, e.code};
            total++;
            if (act !== req) begin
                bad++;
                $display("FAIL %s: {state,cmds,fault,code} got %b_%b_%b_%b want %b_%b_%b_%b", e.name,
                         act[10:8], act[7:4], act[3], act[2:0], req[10:8], req[7:4], req[3], req[2:0]);
            end
`ifdef RPSC_SEQ_FAULT_COUNT_EN
            total++;
            if (bus.fault_count !== e.fcnt) begin
                bad++;
                $display("FAIL %s fault_count: got %0d want %0d", e.name, bus.fault_count, e.fcnt);
            end
`endif
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string nm, input logic [2:0] s, input logic [3:0] cmds,
                              input logic f, input logic [2:0] c);
        exp_t e;
        e.name = nm; e.st = s; e.cmds = cmds; e.flt = f; e.code = c; e.fcnt = 8'(efc);
        q.push_back(e);
    endtask

    // Walk IDLE -> RF_FULL with g2_on / dr_amp_on already high.
    task automatic run_to_full(input string tag);
        bus.start_req = 1'b1;
        step(1); expect_out({tag, "_g2"}, 3'd1, 4'b1000, 1'b0, 3'd0);
        bus.start_req = 1'b0;
        step(1); expect_out({tag, "_drv"}, 3'd2, 4'b1100, 1'b0, 3'd0);
        step(1); expect_out({tag, "_red"}, 3'd3, 4'b1110, 1'b0, 3'd0);
        step(CA); expect_out({tag, "_full"}, 3'd4, 4'b1101, 1'b0, 3'd0);
    endtask

    initial begin
        reset = 1'b1;
        bus.g2_on_perm = 0; bus.g2_on = 0; bus.dr_amp_on_perm = 0; bus.dr_amp_on = 0;
        bus.rf_reduced_permitted = 0; bus.rf_permitted = 0; bus.ca_delay = 0;
        bus.start_req = 0; bus.stop_req = 0; bus.fault_clr = 0;
        step(2); expect_out("reset", 3'd0, 4'b0000, 1'b0, 3'd0);
        reset = 1'b0;

        // Full bring-up with 2-cycle feedback delays.
        bus.g2_on_perm = 1; bus.dr_amp_on_perm = 1; bus.rf_reduced_permitted = 1;
        bus.rf_permitted = 1; bus.ca_delay = 1; bus.start_req = 1;
        step(1); expect_out("up_g2", 3'd1, 4'b1000, 1'b0, 3'd0);
        bus.start_req = 0;
        step(1); expect_out("up_g2_wait", 3'd1, 4'b1000, 1'b0, 3'd0);
        bus.g2_on = 1;
        step(1); expect_out("up_drv", 3'd2, 4'b1100, 1'b0, 3'd0);
        step(1); expect_out("up_drv_wait", 3'd2, 4'b1100, 1'b0, 3'd0);
        bus.dr_amp_on = 1;
        step(1); expect_out("up_red", 3'd3, 4'b1110, 1'b0, 3'd0);
        step(CA - 1); expect_out("up_red_dwell", 3'd3, 4'b1110, 1'b0, 3'd0);
        step(1); expect_out("up_full", 3'd4, 4'b1101, 1'b0, 3'd0);

        // rf_permitted loss falls back to reduced RF and dwell restarts.
        bus.rf_permitted = 0;
        step(1); expect_out("fallback_red", 3'd3, 4'b1110, 1'b0, 3'd0);
        bus.rf_permitted = 1;
        step(CA - 1); expect_out("fallback_dwell", 3'd3, 4'b1110, 1'b0, 3'd0);
        step(1); expect_out("fallback_full", 3'd4, 4'b1101, 1'b0, 3'd0);

        // Orderly shutdown.
        bus.stop_req = 1;
        step(1); expect_out("sd_enter", 3'd5, 4'b1000, 1'b0, 3'd0);
        bus.stop_req = 0; bus.dr_amp_on = 0;
        step(1); expect_out("sd_g2_drop", 3'd5, 4'b0000, 1'b0, 3'd0);
        bus.g2_on = 0;
        step(1); expect_out("sd_idle", 3'd0, 4'b0000, 1'b0, 3'd0);

        // G2 never confirms: timeout after exactly ST cycles.
        bus.start_req = 1;
        step(1); expect_out("to_g2", 3'd1, 4'b1000, 1'b0, 3'd0);
        bus.start_req = 0;
        step(ST - 1); expect_out("to_g2_last", 3'd1, 4'b1000, 1'b0, 3'd0);
        efc++;
        step(1); expect_out("to_fault", 3'd6, 4'b0000, 1'b1, 3'd1);
        bus.fault_clr = 1; bus.start_req = 1;
        step(1); expect_out("clr_blocked", 3'd6, 4'b0000, 1'b1, 3'd1);
        bus.start_req = 0;
        step(1); expect_out("clr_idle", 3'd0, 4'b0000, 1'b0, 3'd0);
        bus.fault_clr = 0;

        // Simultaneous permit loss in RF_REDUCED: code 3 wins over 4.
        bus.g2_on = 1; bus.dr_amp_on = 1; bus.start_req = 1;
        step(1); expect_out("pl_g2", 3'd1, 4'b1000, 1'b0, 3'd0);
        bus.start_req = 0;
        step(1); expect_out("pl_drv", 3'd2, 4'b1100, 1'b0, 3'd0);
        step(1); expect_out("pl_red", 3'd3, 4'b1110, 1'b0, 3'd0);
        bus.g2_on_perm = 0; bus.dr_amp_on_perm = 0;
        efc++;
        step(1); expect_out("pl_fault", 3'd6, 4'b0000, 1'b1, 3'd3);
        bus.g2_on_perm = 1; bus.dr_amp_on_perm = 1; bus.fault_clr = 1;
        step(1); expect_out("pl_clr", 3'd0, 4'b0000, 1'b0, 3'd0);
        bus.fault_clr = 0;

        // Shutdown with dr_amp_on stuck high times out.
        run_to_full("stk");
        bus.stop_req = 1;
        step(1); expect_out("stk_sd", 3'd5, 4'b1000, 1'b0, 3'd0);
        bus.stop_req = 0;
        step(ST - 1); expect_out("stk_sd_last", 3'd5, 4'b1000, 1'b0, 3'd0);
        efc++;
        step(1); expect_out("stk_fault", 3'd6, 4'b0000, 1'b1, 3'd5);
        bus.fault_clr = 1;
        step(1); expect_out("stk_clr", 3'd0, 4'b0000, 1'b0, 3'd0);
        bus.fault_clr = 0;

        // Reset from RF_FULL.
        run_to_full("rst");
        reset = 1; efc = 0;
        step(1); expect_out("rst_mid", 3'd0, 4'b0000, 1'b0, 3'd0);
        reset = 0;

        // Two more faults after reset (G2 permit loss in G2_RAMP).
        for (int k = 0; k < 2; k++) begin
            bus.start_req = 1;
            step(1); expect_out("cnt_g2", 3'd1, 4'b1000, 1'b0, 3'd0);
            bus.start_req = 0; bus.g2_on_perm = 0;
            efc++;
            step(1); expect_out("cnt_fault", 3'd6, 4'b0000, 1'b1, 3'd3);
            bus.g2_on_perm = 1; bus.fault_clr = 1;
            step(1); expect_out("cnt_clr", 3'd0, 4'b0000, 1'b0, 3'd0);
            bus.fault_clr = 0;
        end

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end
endmodule
